// File: rtl/fetch_fifo_arbiter_pkg.sv
// Shared front-end types for the fetch FIFO read-port arbiter.
// Holds the arbiter state enum, requester indices and a reference round-robin pick.
package fetch_fifo_arbiter_pkg;

  localparam int MAX_REQ = 8;

  localparam int REQ_OPCODE = 0;
  localparam int REQ_MODRM  = 1;
  localparam int REQ_IMMED  = 2;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  // Reference round-robin pick: first set bit at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 j;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < n; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fetch_fifo_arbiter_pick.sv
// Round-robin picker: rotate by ptr, priority-encode lowest, unrotate.
// Pure combinational; reusable by other bus arbiters.
module rr_priority_pick
  import fetch_fifo_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_any,
  output logic [PW-1:0] o_idx
);

  logic [N-1:0] w_rot;
  logic [PW:0]  w_map [N];

  // Rotate the request vector so the search always starts at bit 0.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_map[k] = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_map[k] >= (PW+1)'(N)) w_map[k] = w_map[k] - (PW+1)'(N);
      w_rot[k] = i_req[w_map[k]];
    end
  end

  // Lowest set rotated bit wins; map its position back to a requester index.
  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any             = 1'b1;
        o_idx             = w_map[k][PW-1:0];
        o_gnt[w_map[k]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_fifo_arbiter.sv
// Round-robin owner arbiter for the shared instruction-byte FIFO read port.
// Define FETCH_FIFO_ARB_CHECK_EN for protocol_error output and assertions.
module fetch_fifo_arbiter
  import fetch_fifo_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_rd_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] req_fifo_empty,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_count,
  output logic               fifo_rd_en,
`ifdef FETCH_FIFO_ARB_CHECK_EN
  output logic               protocol_error,
`endif
  input  logic               fifo_empty
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_ptr;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [PW-1:0]      w_idx;
  logic [PW-1:0]      w_next_ptr;
  logic               w_owner_req;
  logic               w_pop;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_next_ptr  = (w_idx == PW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
  assign w_owner_req = |(req & r_grant);
  assign w_pop       = ~flush & busy & ~fifo_empty & |(req_rd_en & r_grant);

  assign grant          = r_grant;
  assign busy           = (r_state == ARB_OWNED);
  assign xfer_count     = r_cnt;
  assign fifo_rd_en     = w_pop;
  assign req_fifo_empty = {NUM_REQ{fifo_empty}} | ~r_grant;

  // Ownership FSM: grant, round-robin pointer and per-grant byte counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else if (flush) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_OWNED;
            r_grant <= w_pick;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end
        end
        ARB_OWNED: begin
          if (w_owner_req) begin
            if (w_pop && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end else if (w_any) begin
            r_grant <= w_pick;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end else begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FETCH_FIFO_ARB_CHECK_EN
  logic r_perr;
  logic w_leave;
  logic w_err;

  assign w_leave = busy & ~w_owner_req;
  assign w_err   = |(req_rd_en & ~r_grant)
                 | (w_leave & |(req_rd_en & r_grant))
                 | |(req_rd_en & ~req);
  assign protocol_error = r_perr;

  // Sticky protocol violation flag; a flush clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_perr <= 1'b0;
    else if (flush)  r_perr <= 1'b0;
    else if (w_err)  r_perr <= 1'b1;
  end

  logic [MAX_REQ-1:0] w_ref_req;
  assign w_ref_req = MAX_REQ'(req);

  // Simulation-only invariants on grant shape, pops and picker agreement.
  always @(posedge clk) begin
    if (reset) begin
      assert ($onehot0(r_grant));
      assert (!(fifo_rd_en && fifo_empty));
      assert (MAX_REQ'(w_pick) ==
              rr_pick(w_ref_req, 3'(r_ptr), NUM_REQ));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_fifo_arbiter.sv
// Directed self-checking bench for fetch_fifo_arbiter (NUM_REQ=3, CNT_W=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_fetch_fifo_arbiter;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] req;
  logic [2:0] req_rd_en;
  logic [2:0] grant;
  logic [2:0] req_fifo_empty;
  logic       busy;
  logic [3:0] xfer_count;
  logic       fifo_rd_en;
  logic       fifo_empty;
`ifdef FETCH_FIFO_ARB_CHECK_EN
  logic       protocol_error;
`endif

  int checks = 0;
  int errors = 0;

  fetch_fifo_arbiter #(
    .NUM_REQ (3),
    .CNT_W   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req            (req),
    .req_rd_en      (req_rd_en),
    .grant          (grant),
    .req_fifo_empty (req_fifo_empty),
    .busy           (busy),
    .xfer_count     (xfer_count),
    .fifo_rd_en     (fifo_rd_en),
`ifdef FETCH_FIFO_ARB_CHECK_EN
    .protocol_error (protocol_error),
`endif
    .fifo_empty     (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    req        = 3'b000;
    req_rd_en  = 3'b000;
    fifo_empty = 1'b1;
    nxt();
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", xfer_count, 4'd0);
    check("rst_rfe", req_fifo_empty, 3'b111);
    check("rst_rd", fifo_rd_en, 1'b0);
    reset = 1'b1;
    nxt();

    // Single owner, three pops
    req        = 3'b010;
    fifo_empty = 1'b0;
    #1;
    check("t1_lat", grant, 3'b000);
    nxt();
    #1;
    check("t1_grant", grant, 3'b010);
    check("t1_busy", busy, 1'b1);
    check("t1_rfe", req_fifo_empty, 3'b101);
    req_rd_en = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t1_pop", fifo_rd_en, 1'b1);
      nxt();
    end
    req_rd_en = 3'b000;
    #1;
    check("t1_rd_off", fifo_rd_en, 1'b0);
    check("t1_cnt", xfer_count, 4'd3);
    req = 3'b000;
    nxt();
    #1;
    check("t1_idle", grant, 3'b000);
    check("t1_cnt0", xfer_count, 4'd0);

    // Round-robin handover from rr_ptr=0
    reset = 1'b0;
    #1;
    reset = 1'b1;
    nxt();
    req = 3'b111;
    nxt();
    #1;
    check("t2_g0", grant, 3'b001);
    req_rd_en = 3'b001;
    nxt();
    req_rd_en = 3'b000;
    #1;
    check("t2_cnt1", xfer_count, 4'd1);
    req = 3'b110;
    nxt();
    #1;
    check("t2_g1", grant, 3'b010);
    check("t2_busy1", busy, 1'b1);
    check("t2_cnt_h1", xfer_count, 4'd0);
    req = 3'b100;
    nxt();
    #1;
    check("t2_g2", grant, 3'b100);
    check("t2_busy2", busy, 1'b1);
    check("t2_cnt_h2", xfer_count, 4'd0);
    req = 3'b000;
    nxt();
    #1;
    check("t2_idle", busy, 1'b0);

    // Non-owner read attempt (rr_ptr wrapped to 0)
    req = 3'b001;
    nxt();
    #1;
    check("t3_g0", grant, 3'b001);
    req_rd_en = 3'b100;
    #1;
    check("t3_rd", fifo_rd_en, 1'b0);
    check("t3_rfe2", req_fifo_empty[2], 1'b1);
    nxt();
    req_rd_en = 3'b000;
`ifdef FETCH_FIFO_ARB_CHECK_EN
    #1;
    check("t3_perr", protocol_error, 1'b1);
`endif

    // Owner reads into an empty FIFO, then it fills
    fifo_empty = 1'b1;
    req_rd_en  = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_stall", fifo_rd_en, 1'b0);
      check("t4_rfe0", req_fifo_empty[0], 1'b1);
      nxt();
    end
    fifo_empty = 1'b0;
    #1;
    check("t4_pop", fifo_rd_en, 1'b1);
    nxt();
    req_rd_en = 3'b000;
    #1;
    check("t4_cnt", xfer_count, 4'd1);

    // Flush mid-transfer at count 5
    req_rd_en = 3'b001;
    repeat (4) nxt();
    #1;
    check("t5_cnt5", xfer_count, 4'd5);
    flush = 1'b1;
    #1;
    check("t5_flush_rd", fifo_rd_en, 1'b0);
    nxt();
    flush     = 1'b0;
    req_rd_en = 3'b000;
    #1;
    check("t5_grant0", grant, 3'b000);
    check("t5_cnt0", xfer_count, 4'd0);
`ifdef FETCH_FIFO_ARB_CHECK_EN
    check("t5_perr_clr", protocol_error, 1'b0);
`endif
    nxt();
    #1;
    check("t5_regrant", grant, 3'b001);

    // Counter saturation, then async reset mid-transfer
    req_rd_en = 3'b001;
    repeat (20) nxt();
    #1;
    check("t6_sat", xfer_count, 4'd15);
    check("t6_rd", fifo_rd_en, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_ar_grant", grant, 3'b000);
    check("t6_ar_rd", fifo_rd_en, 1'b0);
    check("t6_ar_busy", busy, 1'b0);
    check("t6_ar_cnt", xfer_count, 4'd0);
    check("t6_ar_rfe", req_fifo_empty, 3'b111);
    req       = 3'b000;
    req_rd_en = 3'b000;
    nxt();
    reset = 1'b1;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
